toggle_counter_ctrl: RTL and testbench

Programmable modulo up/down counter whose state lives in a bank of T flip-flops; the controller computes the per-bit toggle mask every cycle instead of loading a D register. It gives the lab a start/stop/clear command interface, wrap detection and one-shot mode. It drives the seven-segment and LED datapaths and is the sequencing layer above the T flip-flop primitive.

---
 rtl/counter_pkg.sv | 12 +
 rtl/t_ff_bank.sv | 19 +
 rtl/toggle_counter_ctrl.sv | 103 ++++++++++
 tb/tb_toggle_counter_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the toggle-mask counter: controller state encoding and default width.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/t_ff_bank.sv
// N-wide bank of T flip-flops; each bit inverts when its T input is high.
module t_ff_bank #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] T,
  output logic [N-1:0] Q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q <= '0;
    end else begin
      Q <= Q ^ T;
    end
  end

endmodule

// File: rtl/toggle_counter_ctrl.sv
// Modulo up/down counter controller: derives a toggle mask for the T flip-flop bank each cycle
// and sequences IDLE/RUN/DONE with clear > stop > start command priority.
module toggle_counter_ctrl
  import counter_pkg::*;
#(
  parameter int N = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         up,
  input  logic         one_shot,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_tc;
  logic         w_tc_nxt;
  logic [N-1:0] w_next;
  logic         w_wrap;
  logic [N-1:0] w_toggle;

  t_ff_bank #(.N(N)) u_bank (
    .clk   (clk),
    .reset (reset),
    .T     (w_toggle),
    .Q     (count)
  );

  // Candidate next count; a count above limit (limit lowered mid-run) snaps back into range.
  always_comb begin
    w_next = count;
    w_wrap = 1'b0;
    if (up) begin
      if (count >= limit) begin
        w_next = '0;
        w_wrap = 1'b1;
      end else begin
        w_next = count + N'(1);
      end
    end else begin
      if (count == '0) begin
        w_next = limit;
        w_wrap = 1'b1;
      end else if (count > limit) begin
        w_next = limit;
      end else begin
        w_next = count - N'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tc_nxt    = 1'b0;
    w_toggle    = '0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_toggle    = count;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!stop && start) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_toggle = count ^ w_next;
            w_tc_nxt = w_wrap;
            if (one_shot && w_wrap) w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (!stop && start) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign tc   = r_tc;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_toggle_counter_ctrl.sv
// Bench for toggle_counter_ctrl: directed scenarios plus random commands against a cycle model.
module tb_toggle_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic       up = 1'b1, one_shot = 1'b0;
  logic [7:0] limit = 8'd5;
  logic [7:0] count;
  logic       tc, busy, done;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 = idle, 1 = running, 2 = finished
  int m_mode = 0;
  int m_cnt  = 0;
  bit m_tc   = 1'b0;

  toggle_counter_ctrl #(.N(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up       (up),
    .one_shot (one_shot),
    .limit    (limit),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_tc   = 1'b0;
  endfunction

  function automatic void model_edge();
    int lim;
    lim = int'(limit);
    if (clear) begin
      m_mode = 0;
      m_cnt  = 0;
      m_tc   = 1'b0;
    end else if (m_mode == 1) begin
      if (stop) begin
        m_mode = 0;
        m_tc   = 1'b0;
      end else begin
        m_tc = 1'b0;
        if (up) begin
          if (m_cnt >= lim) begin m_cnt = 0; m_tc = 1'b1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = lim; m_tc = 1'b1; end
          else if (m_cnt > lim) m_cnt = lim;
          else m_cnt = m_cnt - 1;
        end
        if (one_shot && m_tc) m_mode = 2;
      end
    end else begin
      m_tc = 1'b0;
      if (!stop && start) m_mode = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cmd_clear();
    start = 1'b0; stop = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_vec++;
    if ({count, tc, busy, done} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state: got count=%0d tc=%b busy=%b done=%b, want all 0", count, tc, busy, done);
    end
    reset = 1'b0;
    model_reset();
    tick();
    n_vec++;
    if ({count, busy} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_idle: got count=%0d busy=%b, want 0/0", count, busy);
    end
  endtask

  task automatic test_up_count();
    logic [7:0] exp [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    limit = 8'd5; up = 1'b1; one_shot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if ({count, busy} !== {8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL up_start_edge: got count=%0d busy=%b, want 0/1", count, busy);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_vec++;
      if ({count, tc, busy} !== {exp[i], (exp[i] == 8'd0), 1'b1}) begin
        n_err++;
        $display("FAIL up_seq[%0d]: got count=%0d tc=%b busy=%b, want %0d/%b/1", i, count, tc, busy, exp[i], (exp[i] == 8'd0));
      end
    end
    cmd_clear();
  endtask

  task automatic test_down_oneshot();
    logic [7:0] exp [3] = '{8'd2, 8'd1, 8'd0};
    limit = 8'd3; up = 1'b0; one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if ({count, tc, done, busy} !== {8'd3, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL down_wrap: got count=%0d tc=%b done=%b busy=%b, want 3/1/1/0", count, tc, done, busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({count, tc, done} !== {8'd3, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL done_hold[%0d]: got count=%0d tc=%b done=%b, want 3/0/1", i, count, tc, done);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if ({count, busy, done} !== {8'd3, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL done_restart: got count=%0d busy=%b done=%b, want 3/1/0", count, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({count, busy} !== {exp[i], 1'b1}) begin
        n_err++;
        $display("FAIL down_seq[%0d]: got count=%0d busy=%b, want %0d/1", i, count, busy, exp[i]);
      end
    end
    cmd_clear();
  endtask

  task automatic test_priority();
    limit = 8'd10; up = 1'b1; one_shot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (count !== 8'd4) begin
      n_err++;
      $display("FAIL prio_setup: got count=%0d, want 4", count);
    end
    start = 1'b1; stop = 1'b1; clear = 1'b1;
    tick();
    n_vec++;
    if ({count, tc, busy, done} !== 11'd0) begin
      n_err++;
      $display("FAIL prio_clear: got count=%0d tc=%b busy=%b done=%b, want 0/0/0/0", count, tc, busy, done);
    end
    clear = 1'b0;
    tick();
    n_vec++;
    if ({count, busy, done} !== 10'd0) begin
      n_err++;
      $display("FAIL prio_start_stop_idle: got count=%0d busy=%b done=%b, want 0/0/0", count, busy, done);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_limit_change();
    for (int dir = 1; dir >= 0; dir--) begin
      cmd_clear();
      limit = 8'd200; up = 1'b1; one_shot = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (150) tick();
      n_vec++;
      if (count !== 8'd150) begin
        n_err++;
        $display("FAIL lim_setup_%0d: got count=%0d, want 150", dir, count);
      end
      limit = 8'd100; up = dir[0];
      tick();
      n_vec++;
      if (dir == 1 && {count, tc} !== {8'd0, 1'b1}) begin
        n_err++;
        $display("FAIL lim_lower_up: got count=%0d tc=%b, want 0/1", count, tc);
      end
      if (dir == 0 && {count, tc} !== {8'd100, 1'b0}) begin
        n_err++;
        $display("FAIL lim_lower_down: got count=%0d tc=%b, want 100/0", count, tc);
      end
    end
    cmd_clear();
  endtask

  task automatic test_degenerate();
    limit = 8'd0; up = 1'b1; one_shot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({count, tc, busy} !== {8'd0, 1'b1, 1'b1}) begin
        n_err++;
        $display("FAIL lim0_run[%0d]: got count=%0d tc=%b busy=%b, want 0/1/1", i, count, tc, busy);
      end
    end
    cmd_clear();
    one_shot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if ({count, tc, done} !== {8'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL lim0_oneshot: got count=%0d tc=%b done=%b, want 0/1/1", count, tc, done);
    end
    tick();
    n_vec++;
    if ({count, tc, done} !== {8'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL lim0_oneshot_after: got count=%0d tc=%b done=%b, want 0/0/1", count, tc, done);
    end
    cmd_clear();
  endtask

  task automatic test_async_reset();
    limit = 8'd20; up = 1'b1; one_shot = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    n_vec++;
    if (count !== 8'd7) begin
      n_err++;
      $display("FAIL areset_setup: got count=%0d, want 7", count);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({count, tc, busy, done} !== 11'd0) begin
      n_err++;
      $display("FAIL areset_immediate: got count=%0d tc=%b busy=%b done=%b, want all 0", count, tc, busy, done);
    end
    model_reset();
    #3 reset = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({count, busy} !== 9'd0) begin
      n_err++;
      $display("FAIL areset_stays_idle: got count=%0d busy=%b, want 0/0", count, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if ({count, busy} !== {8'd1, 1'b1}) begin
      n_err++;
      $display("FAIL areset_resume: got count=%0d busy=%b, want 1/1", count, busy);
    end
    cmd_clear();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      clear    = ($urandom_range(0, 31) == 0);
      stop     = ($urandom_range(0, 15) == 0);
      start    = ($urandom_range(0, 3) == 0);
      up       = ($urandom_range(0, 7) != 0) ? up : ~up;
      one_shot = ($urandom_range(0, 63) == 0) ? ~one_shot : one_shot;
      if ($urandom_range(0, 19) == 0)
        limit = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      tick();
      n_vec++;
      if ({count, tc, busy, done} !== {8'(m_cnt), m_tc, (m_mode == 1), (m_mode == 2)}) begin
        n_err++;
        $display("FAIL random[%0d]: got count=%0d tc=%b busy=%b done=%b, want %0d/%b/%b/%b",
                 i, count, tc, busy, done, m_cnt, m_tc, (m_mode == 1), (m_mode == 2));
      end
    end
    cmd_clear();
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_oneshot();
    test_priority();
    test_limit_change();
    test_degenerate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
